alu_mul_sequencer: RTL

//  Multi-cycle shift-add multiplier controller that borrows the shared ALU adder (ALUctrl=3'b000).

---
 rtl/alu_mul_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared ALU adder, one add per cycle,
// returning the low WIDTH bits of op_a*op_b with a one-cycle done pulse.
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             last_iter;

    // Stop after WIDTH adds, or as soon as no set multiplier bits remain above the current one.
    assign last_iter = (count == CW'(WIDTH - 1)) ||
                       (EARLY_EXIT && ((mplier >> 1) == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_own <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= op_a;
                        mplier  <= op_b;
                        acc     <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        alu_own <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        product <= alu_result;
                        busy    <= 1'b0;
                        alu_own <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    alu_own <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Operands are forced to zero whenever the datapath is not lent to this block.
    assign alu_op1  = alu_own ? acc : '0;
    assign alu_op2  = (alu_own && mplier[0]) ? mcand : '0;
    assign alu_ctrl = 3'b000;

endmodule
